adc_fft_packetizer: RTL and testbench
=====================================

Name: adc_fft_packetizer

Overview:
- Upstream stage of the FFT dual-clock FIFO.
- Each start pulse causes the block to take free-running 14-bit ADC samples and discard a programmable number of leading samples.
- It then frames the next frame_len samples as one Avalon-ST packet (SOP on the first sample, EOP on the last) and presents it to the FIFO's write-side streaming interface.
- A small internal buffer absorbs ready backpressure; samples lost to overflow are flagged.

Parameters:
DATA_W, 14, sample width; equals the FIFO data width.
LEN_W, 16, width of the skip and frame-length counters.
BUF_DEPTH, 4, internal buffer entries; power of 2, ≥2.

Ports:
adc_pkt_clk_clk  in  1  single clock; ADC and FIFO write side share it.
adc_pkt_clk_reset_reset_n  in  1  asynchronous active-low reset.
adc_data  in  DATA_W  ADC sample.
adc_valid  in  1  one-cycle strobe per new sample.
start  in  1  pulse; arms a capture when idle.
skip_cnt  in  LEN_W  samples to discard after start.
frame_len  in  LEN_W  samples per packet.
clr_ovf  in  1  clears the sticky overflow flag.
adc_pkt_out_data  out  DATA_W  packet sample.
adc_pkt_out_valid  out  1  Avalon-ST valid.
adc_pkt_out_ready  in  1  Avalon-ST ready from the FIFO.
adc_pkt_out_startofpacket  out  1  first sample of the packet.
adc_pkt_out_endofpacket  out  1  last sample of the packet.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse when the packet has fully drained.
overflow  out  1  sticky; a sample was dropped because the buffer was full.

Behaviour:
- Reset (async assert, sync deassert assumed external):
  - state=IDLE; counters and buffer pointers cleared.
  - out_valid, sop, eop, busy, done, overflow all 0; out_data 0.
  - A reset mid-operation abandons the packet; no EOP is emitted.
- States: IDLE, SKIP, CAPTURE, DRAIN.
- IDLE:
  - start=1 with frame_len≠0 latches skip_cnt and frame_len.
  - It goes to SKIP if skip_cnt≠0, else to CAPTURE.
  - start with frame_len=0 is ignored (no done).
  - start is ignored in all other states.
- SKIP:
  - Each adc_valid increments the skip counter.
  - On the adc_valid that makes the count equal the latched skip_cnt, go to CAPTURE.
  - That sample is discarded. CAPTURE begins with the next adc_valid.
- CAPTURE:
  - Each adc_valid pushes {data, sop, eop} into the buffer.
  - sop=1 on sample index 0; eop=1 on index frame_len-1.
  - After index frame_len-1, go to DRAIN.
  - The sample counter advances on every adc_valid, whether or not the push succeeds.
- DRAIN: when the buffer becomes empty, go to IDLE and pulse done for 1 cycle in that same cycle.
- Buffer:
  - Show-ahead FIFO, BUF_DEPTH entries.
  - out_valid = not empty; out_data, sop and eop come from the head entry.
  - A pop occurs when out_valid & out_ready.
  - A push is accepted when count<BUF_DEPTH, or when a pop happens in the same cycle (simultaneous push/pop at full is allowed; count unchanged).
  - Latency: a sample pushed at edge N is visible at the output from edge N onward (valid in cycle N+1).
  - Output fields hold stable while out_valid & !out_ready.
- Overflow:
  - If a push is refused, the sample is dropped and overflow is set.
  - If the dropped sample carried eop, the eop bit of the most recently written entry is set instead, so every packet still terminates.
  - SOP is never dropped, because the buffer is empty on entry to CAPTURE (DRAIN guarantees this).
  - clr_ovf clears overflow. A simultaneous set wins.
- frame_len=1: the single sample carries sop=1 and eop=1.
- adc_valid outside SKIP/CAPTURE is ignored.

Test Plan:
1. Nominal: skip_cnt=3, frame_len=8, out_ready=1, adc_valid every cycle with data 0..20.
   -> Packet data 3..10; SOP with data 3, EOP with data 10; done 1 cycle after the last pop; overflow=0.
2. Backpressure: frame_len=16, skip=0, BUF_DEPTH=4, adc_valid every 4th cycle, out_ready toggled 50%.
   -> All 16 samples in order, no overflow, data stable while stalled.
3. Overflow: frame_len=8, skip=0, out_ready=0 for 10 cycles, adc_valid every cycle, then ready=1.
   -> Samples 0..3 emitted; 4..7 dropped; EOP on sample 3; overflow=1 until clr_ovf.
4. Edge lengths: frame_len=1, skip=0 -> single beat with sop=eop=1. frame_len=0 -> busy stays 0, no done.
5. Start while busy, plus full-buffer simultaneity: second start during CAPTURE is ignored, packet length unchanged. Push+pop at count=4 -> accepted, count stays 4.
6. Reset mid-CAPTURE after 5 of 8 samples:
   -> All outputs 0 immediately.
   -> Next start (skip 0, len 4) yields a clean 4-sample packet with SOP.

Source files
------------

// File: rtl/adc_fft_packetizer.sv
// ADC sample packetizer: skips leading samples after a start pulse, frames the
// next frame_len samples as one Avalon-ST packet through a small show-ahead buffer.
`timescale 1ns/1ps
module adc_fft_packetizer #(
    parameter int DATA_W    = 14,
    parameter int LEN_W     = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic              adc_pkt_clk_clk,
    input  logic              adc_pkt_clk_reset_reset_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              start,
    input  logic [LEN_W-1:0]  skip_cnt,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] adc_pkt_out_data,
    output logic              adc_pkt_out_valid,
    input  logic              adc_pkt_out_ready,
    output logic              adc_pkt_out_startofpacket,
    output logic              adc_pkt_out_endofpacket,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DRAIN} state_t;

    state_t            state;
    logic [LEN_W-1:0]  skip_lat, len_lat, cnt, cnt_inc;
    logic [DATA_W-1:0] mem_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] mem_sop, mem_eop;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nxt;
    logic              pop, push_req, push_ok, drop, smp_sop, smp_eop;

    assign adc_pkt_out_valid         = (count != '0);
    assign adc_pkt_out_data          = mem_data[rd_ptr];
    assign adc_pkt_out_startofpacket = adc_pkt_out_valid & mem_sop[rd_ptr];
    assign adc_pkt_out_endofpacket   = adc_pkt_out_valid & mem_eop[rd_ptr];

    assign pop      = adc_pkt_out_valid & adc_pkt_out_ready;
    assign push_req = (state == CAPTURE) & adc_valid;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push_ok  = push_req & ((count < DEPTH_C) | pop);
    assign drop     = push_req & ~push_ok;
    assign cnt_inc  = cnt + 1'b1;
    assign smp_sop  = (cnt == '0);
    assign smp_eop  = (cnt == len_lat - 1'b1);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop)
            count_nxt = count + 1'b1;
        else if (!push_ok && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge adc_pkt_clk_clk or negedge adc_pkt_clk_reset_reset_n) begin
        if (!adc_pkt_clk_reset_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mem_sop <= '0;
            mem_eop <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                mem_data[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_data[wr_ptr] <= adc_data;
                mem_sop[wr_ptr]  <= smp_sop;
                mem_eop[wr_ptr]  <= smp_eop;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            // Dropped last sample: terminate the packet on the newest stored entry.
            if (drop && smp_eop)
                mem_eop[wr_ptr - 1'b1] <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge adc_pkt_clk_clk or negedge adc_pkt_clk_reset_reset_n) begin
        if (!adc_pkt_clk_reset_reset_n) begin
            state    <= IDLE;
            skip_lat <= '0;
            len_lat  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && frame_len != '0) begin
                        skip_lat <= skip_cnt;
                        len_lat  <= frame_len;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= (skip_cnt != '0) ? SKIP : CAPTURE;
                    end
                end
                SKIP: begin
                    if (adc_valid) begin
                        if (cnt_inc == skip_lat) begin
                            cnt   <= '0;
                            state <= CAPTURE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                CAPTURE: begin
                    if (adc_valid) begin
                        if (smp_eop) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                DRAIN: begin
                    if (count_nxt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_fft_packetizer.sv
// Directed bench for adc_fft_packetizer: nominal framing, backpressure,
// overflow, edge lengths, start-while-busy and mid-capture reset.
`timescale 1ns/1ps
module tb_adc_fft_packetizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        start = 1'b0;
    logic [15:0] skip_cnt = '0;
    logic [15:0] frame_len = '0;
    logic        clr_ovf = 1'b0;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop, out_eop;
    logic        busy, done, overflow;

    int n_chk = 0;
    int n_err = 0;

    int pop_d[$];
    int pop_s[$];
    int pop_e[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_pop = 0;
    int cyc_n = 0;
    logic stall_prev = 1'b0;
    int prev_d = 0, prev_s = 0, prev_e = 0;

    adc_fft_packetizer #(.DATA_W(14), .LEN_W(16), .BUF_DEPTH(4)) dut (
        .adc_pkt_clk_clk           (clk),
        .adc_pkt_clk_reset_reset_n (rst_n),
        .adc_data                  (adc_data),
        .adc_valid                 (adc_valid),
        .start                     (start),
        .skip_cnt                  (skip_cnt),
        .frame_len                 (frame_len),
        .clr_ovf                   (clr_ovf),
        .adc_pkt_out_data          (out_data),
        .adc_pkt_out_valid         (out_valid),
        .adc_pkt_out_ready         (out_ready),
        .adc_pkt_out_startofpacket (out_sop),
        .adc_pkt_out_endofpacket   (out_eop),
        .busy                      (busy),
        .done                      (done),
        .overflow                  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Negedge monitor: collects handshakes, done pulses, and checks stall stability.
    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), prev_d);
                chk("stall_sop", int'(out_sop), prev_s);
                chk("stall_eop", int'(out_eop), prev_e);
            end
            if (out_valid && out_ready) begin
                pop_d.push_back(int'(out_data));
                pop_s.push_back(int'(out_sop));
                pop_e.push_back(int'(out_eop));
                last_pop = cyc_n;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            stall_prev = out_valid && !out_ready;
            prev_d = int'(out_data);
            prev_s = int'(out_sop);
            prev_e = int'(out_eop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pkt(input string tag, input int pb, input int n, input int d0);
        chk({tag, "_len"}, pop_d.size() - pb, n);
        for (int i = 0; i < n; i++) begin
            if (pb + i < pop_d.size()) begin
                chk({tag, "_data"}, pop_d[pb+i], d0 + i);
                chk({tag, "_sop"}, pop_s[pb+i], (i == 0) ? 1 : 0);
                chk({tag, "_eop"}, pop_e[pb+i], (i == n - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic kick(input int skip, input int len);
        skip_cnt  = 16'(skip);
        frame_len = 16'(len);
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int pb, db;

        repeat (3) tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_sop", int'(out_sop), 0);
        chk("rst_eop", int'(out_eop), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Nominal: skip 3, len 8, data 0..20 every cycle
        pb = pop_d.size(); db = done_cnt;
        out_ready = 1'b1;
        kick(3, 8);
        chk("t1_busy", int'(busy), 1);
        for (int k = 0; k <= 20; k++) begin
            adc_valid = 1'b1; adc_data = 14'(k);
            tick();
        end
        adc_valid = 1'b0;
        repeat (5) tick();
        chk_pkt("t1", pb, 8, 3);
        chk("t1_done", done_cnt - db, 1);
        chk("t1_done_lat", done_cyc - last_pop, 1);
        chk("t1_ovf", int'(overflow), 0);
        chk("t1_idle", int'(busy), 0);

        // Backpressure: sample every 4th cycle, ready low on even cycles
        pb = pop_d.size(); db = done_cnt;
        kick(0, 16);
        begin
            int k = 0;
            for (int i = 0; i < 80; i++) begin
                adc_valid = (i % 4 == 0) && (k < 16);
                adc_data  = 14'(100 + k);
                if (adc_valid) k++;
                out_ready = (i % 2 == 1);
                tick();
            end
        end
        adc_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        chk_pkt("t2", pb, 16, 100);
        chk("t2_ovf", int'(overflow), 0);
        chk("t2_done", done_cnt - db, 1);

        // Overflow: ready low 10 cycles, 8 back-to-back samples
        pb = pop_d.size(); db = done_cnt;
        out_ready = 1'b0;
        kick(0, 8);
        for (int i = 0; i < 20; i++) begin
            adc_valid = (i < 8);
            adc_data  = 14'(200 + i);
            out_ready = (i >= 10);
            tick();
        end
        adc_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        chk_pkt("t3", pb, 4, 200);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_done", done_cnt - db, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", int'(overflow), 0);

        // frame_len = 1
        pb = pop_d.size(); db = done_cnt;
        kick(0, 1);
        adc_valid = 1'b1; adc_data = 14'd300;
        tick();
        adc_valid = 1'b0;
        repeat (5) tick();
        chk_pkt("t4a", pb, 1, 300);
        chk("t4a_done", done_cnt - db, 1);

        // frame_len = 0 is ignored
        pb = pop_d.size(); db = done_cnt;
        kick(0, 0);
        chk("t4b_busy0", int'(busy), 0);
        adc_valid = 1'b1; adc_data = 14'd333;
        repeat (4) tick();
        adc_valid = 1'b0;
        repeat (3) tick();
        chk("t4b_busy1", int'(busy), 0);
        chk("t4b_done", done_cnt - db, 0);
        chk("t4b_pops", pop_d.size() - pb, 0);

        // Start while busy ignored; push+pop while full
        pb = pop_d.size(); db = done_cnt;
        out_ready = 1'b0;
        kick(0, 8);
        for (int i = 0; i < 8; i++) begin
            adc_valid = 1'b1;
            adc_data  = 14'(400 + i);
            out_ready = (i >= 4);
            start     = (i == 2);
            frame_len = (i == 2) ? 16'd3 : 16'd8;
            tick();
        end
        start = 1'b0; adc_valid = 1'b0; out_ready = 1'b1;
        repeat (8) tick();
        chk_pkt("t5", pb, 8, 400);
        chk("t5_ovf", int'(overflow), 0);
        chk("t5_done", done_cnt - db, 1);

        // Reset mid-capture after 5 of 8 samples
        out_ready = 1'b0;
        kick(0, 8);
        for (int i = 0; i < 5; i++) begin
            adc_valid = 1'b1; adc_data = 14'(500 + i);
            tick();
        end
        adc_valid = 1'b0;
        chk("t6_pre_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_data", int'(out_data), 0);
        chk("t6_sop", int'(out_sop), 0);
        chk("t6_eop", int'(out_eop), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_ovf", int'(overflow), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pb = pop_d.size(); db = done_cnt;
        out_ready = 1'b1;
        kick(0, 4);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1; adc_data = 14'(600 + i);
            tick();
        end
        adc_valid = 1'b0;
        repeat (6) tick();
        chk_pkt("t6r", pb, 4, 600);
        chk("t6r_done", done_cnt - db, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
